// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types, width helpers and saturation for the sequential neuron layer
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Accumulator width: one product plus enough headroom for N_IN terms.
  function automatic int acc_width(input int xw, input int ww, input int n_in);
    return xw + ww + $clog2(n_in);
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Clamp an unsigned value to the largest OW-bit code.
  function automatic logic [31:0] sat(input logic [31:0] v, input int ow);
    logic [31:0] max_v;
    max_v = (32'd1 << ow) - 32'd1;
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// rtl/nn_mac_unit.sv - registered multiply-accumulate with clear and saturating result
module nn_mac_unit
  import nn_pkg::*;
#(
  parameter int XW   = 4,
  parameter int WW   = 4,
  parameter int ACCW = 10,
  parameter int OW   = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            acc_en_i,
  input  logic [XW-1:0]   a_i,
  input  logic [WW-1:0]   b_i,
  output logic [OW-1:0]   sat_o
);

  localparam int PW = XW + WW;

  logic [PW-1:0]   prod;
  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] sum;
  logic [31:0]     sat_full;

  // Product and running sum including the current term, so the last term of a
  // neuron can be saturated and stored in the same cycle it is multiplied.
  always_comb begin
    prod     = {{WW{1'b0}}, a_i} * {{XW{1'b0}}, b_i};
    sum      = acc_q + {{(ACCW-PW){1'b0}}, prod};
    sat_full = sat(32'(sum), OW);
    sat_o    = sat_full[OW-1:0];
  end

  // Accumulator register; clear wins over accumulate so a neuron boundary restarts at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (acc_en_i) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/nn_layer_seq.sv
// rtl/nn_layer_seq.sv - time-multiplexed fully-connected layer sharing a single MAC
module nn_layer_seq
  import nn_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 8,
  parameter int XW    = 4,
  parameter int WW    = 4,
  parameter int OW    = 10
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               en_i,
  input  logic                               wr_en_i,
  input  logic [idx_width(N_IN*N_OUT)-1:0]   wr_addr_i,
  input  logic [WW-1:0]                      wr_data_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [N_IN*XW-1:0]                 x_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [N_OUT*OW-1:0]                y_o,
  output logic [1:0]                         state_o
);

  localparam int NW   = N_IN * N_OUT;
  localparam int AW   = idx_width(NW);
  localparam int IW   = idx_width(N_IN);
  localparam int JW   = idx_width(N_OUT);
  localparam int ACCW = acc_width(XW, WW, N_IN);

  state_t          state_q, state_d;
  logic [IW-1:0]   i_q;
  logic [JW-1:0]   j_q;
  logic [XW-1:0]   x_q [N_IN];
  logic [WW-1:0]   w_q [NW];
  logic [OW-1:0]   y_q [N_OUT];

  logic            accept, step, last_i, last_j, release_out;
  int              rd_idx;
  logic [XW-1:0]   x_cur;
  logic [WW-1:0]   w_cur;
  logic [OW-1:0]   mac_sat;

  // Handshake qualifiers and the operand pair selected by the (j, i) counters.
  always_comb begin
    accept      = (state_q == ST_IDLE) && in_valid_i && en_i;
    step        = (state_q == ST_MAC) && en_i;
    release_out = (state_q == ST_DONE) && out_ready_i && en_i;
    last_i      = (i_q == IW'(N_IN - 1));
    last_j      = (j_q == JW'(N_OUT - 1));
    rd_idx      = int'(j_q) * N_IN + int'(i_q);
    x_cur       = x_q[i_q];
    w_cur       = w_q[rd_idx[AW-1:0]];
  end

  nn_mac_unit #(
    .XW   (XW),
    .WW   (WW),
    .ACCW (ACCW),
    .OW   (OW)
  ) u_mac (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (accept || (step && last_i)),
    .acc_en_i (step),
    .a_i      (x_cur),
    .b_i      (w_cur),
    .sat_o    (mac_sat)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_MAC;
      ST_MAC:  if (step && last_i && last_j) state_d = ST_DONE;
      ST_DONE: if (release_out) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready_o  = (state_q == ST_IDLE);
    out_valid_o = (state_q == ST_DONE);
    state_o     = state_q;
  end

  // Counters, captured input vector and per-neuron result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_q <= '0;
      j_q <= '0;
      for (int k = 0; k < N_IN; k++) x_q[k] <= '0;
      for (int k = 0; k < N_OUT; k++) y_q[k] <= '0;
    end else if (accept) begin
      i_q <= '0;
      j_q <= '0;
      for (int k = 0; k < N_IN; k++) x_q[k] <= x_i[k*XW +: XW];
    end else if (step) begin
      if (last_i) begin
        i_q      <= '0;
        y_q[j_q] <= mac_sat;
        j_q      <= last_j ? '0 : j_q + JW'(1);
      end else begin
        i_q <= i_q + IW'(1);
      end
    end
  end

  // Weight register file; writes land at the clock edge, so a same-cycle read sees the old value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NW; k++) w_q[k] <= WW'(1);
    end else if (wr_en_i && (int'(wr_addr_i) < NW)) begin
      w_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Flatten result registers onto the output bus.
  always_comb begin
    y_o = '0;
    for (int k = 0; k < N_OUT; k++) y_o[k*OW +: OW] = y_q[k];
  end

endmodule
